// File: rtl/cache_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the port arbiter and the
// CPU-side port of the cache.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              p0_rd_req;
    logic [ADDR_W-1:0] p0_addr;
    logic [31:0]       p0_rd_data;
    logic              p0_stall;
    logic              p0_done;

    logic              p1_rd_req;
    logic              p1_wr_req;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p1_wr_data;
    logic [31:0]       p1_rd_data;
    logic              p1_stall;
    logic              p1_done;

    logic [ADDR_W-1:0] c_addr;
    logic              c_rd_req;
    logic              c_wr_req;
    logic [31:0]       c_wr_data;
    logic [31:0]       c_rd_data;
    logic              c_miss;

    modport master (
        input  p0_rd_req, p0_addr,
        output p0_rd_data, p0_stall, p0_done,
        input  p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
        output p1_rd_data, p1_stall, p1_done,
        output c_addr, c_rd_req, c_wr_req, c_wr_data,
        input  c_rd_data, c_miss
    );

    modport slave (
        output p0_rd_req, p0_addr,
        input  p0_rd_data, p0_stall, p0_done,
        output p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
        input  p1_rd_data, p1_stall, p1_done,
        input  c_addr, c_rd_req, c_wr_req, c_wr_data,
        output c_rd_data, c_miss
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares the cache CPU port between fetch (port 0) and load/store (port 1)
// with round-robin arbitration and saturating statistics counters.
module cache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_port_arbiter_if.master bus,
    output logic [CNT_W-1:0]     acc_cnt0,
    output logic [CNT_W-1:0]     acc_cnt1,
    output logic [CNT_W-1:0]     miss_cyc_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata0_q, rdata0_d;
    logic [31:0]       rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  acc0_q, acc0_d;
    logic [CNT_W-1:0]  acc1_q, acc1_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic req0;
    logic req1;
    logic gnt;
    logic resp;
    logic done0;
    logic done1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign req0 = bus.p0_rd_req;
    assign req1 = bus.p1_rd_req | bus.p1_wr_req;

    // On a tie the port that did not win last time gets the grant
    assign gnt = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        acc0_d   = acc0_q;
        acc1_d   = acc1_q;
        miss_d   = miss_q;
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    addr_d  = gnt ? bus.p1_addr : bus.p0_addr;
                    wdata_d = gnt ? bus.p1_wr_data : 32'h0;
                    wr_d    = gnt & bus.p1_wr_req;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.c_miss) begin
                    miss_d = sat_inc(miss_q);
                end else begin
                    state_d = RESP;
                    if (owner_q) acc1_d = sat_inc(acc1_q);
                    else         acc0_d = sat_inc(acc0_q);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (!wr_q) begin
                    if (owner_q) rdata1_d = bus.c_rd_data;
                    else         rdata0_d = bus.c_rd_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            acc0_q   <= '0;
            acc1_q   <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            acc0_q   <= acc0_d;
            acc1_q   <= acc1_d;
            miss_q   <= miss_d;
        end
    end

    assign resp  = (state_q == RESP);
    assign done0 = resp & ~owner_q;
    assign done1 = resp & owner_q;

    // Cache side is driven only from the latched request
    assign bus.c_addr    = addr_q;
    assign bus.c_wr_data = wdata_q;
    assign bus.c_rd_req  = (state_q == BUSY) & ~wr_q;
    assign bus.c_wr_req  = (state_q == BUSY) & wr_q;

    // Read data is forwarded in the done cycle, then held in the register
    assign bus.p0_rd_data = (done0 & ~wr_q) ? bus.c_rd_data : rdata0_q;
    assign bus.p1_rd_data = (done1 & ~wr_q) ? bus.c_rd_data : rdata1_q;
    assign bus.p0_done    = done0;
    assign bus.p1_done    = done1;
    assign bus.p0_stall   = req0 & ~done0;
    assign bus.p1_stall   = req1 & ~done1;

    assign acc_cnt0     = acc0_q;
    assign acc_cnt1     = acc1_q;
    assign miss_cyc_cnt = miss_q;

endmodule
